// File: rtl/ysyx_22041207_ifu_pkg.sv
// Shared IFU definitions: widths, reset PC, NOP encoding, FSM states,
// the decoder-facing payload and the doubleword-to-instruction select.
package ysyx_22041207_ifu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  // Instruction payload handed to the decoder.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
    logic              fault;
  } ifu_out_t;

  localparam ifu_out_t IFU_OUT_RST = '{inst: NOP_INST, pc: '0, fault: 1'b0};

  // Pick the 32-bit word of a doubleword addressed by pc[2].
  function automatic logic [INST_W-1:0] select_inst(input logic [DATA_W-1:0] rdata,
                                                    input logic              hi);
    return hi ? rdata[DATA_W-1:INST_W] : rdata[INST_W-1:0];
  endfunction

endpackage

// File: rtl/ysyx_22041207_pc_reg.sv
// Architectural PC register with its next-PC select.
// Ports:
//   clk, rst_n     clock, async active-low reset (pc <= RESET_PC)
//   redirect_i     load redirect target (word aligned) next cycle
//   redirect_pc_i  redirect target; bits [1:0] are dropped
//   advance_i      pc <= pc + 4 (wraps modulo 2^XLEN)
//   pc_o           current pc
module ysyx_22041207_pc_reg
  import ysyx_22041207_ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Low target bits are forced to zero, so they are intentionally unused.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Redirect wins over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: owns the PC, fetches doublewords over a
// valid/ready memory port (one request outstanding) and hands one
// instruction at a time to the decoder. Redirects flush any in-flight fetch.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/ready, imem_addr    fetch request (8-byte aligned address)
//   imem_resp_valid/rdata/resp_err     fetch response (single-cycle pulse)
//   inst_valid/ready, inst, inst_pc,   decoder handshake and payload;
//   inst_fault                         inst is NOP_INST on a faulting fetch
//   redirect_valid, redirect_pc        PC redirect pulse from execute/trap
module ysyx_22041207_ifu
  import ysyx_22041207_ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
);

  ifu_state_e      state_q, state_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  ifu_out_t        out_q, out_d;
  logic            advance;
  logic            redirect_en;
  logic [XLEN-1:0] pc;

  // Redirects are ignored in the single post-reset IDLE cycle.
  assign redirect_en = redirect_valid && (state_q != IFU_IDLE);

  ysyx_22041207_pc_reg u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_en),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance),
    .pc_o          (pc)
  );

  // Next state, drop flag, payload capture and registered output enables.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    out_d        = out_q;
    advance      = 1'b0;
    req_valid_d  = 1'b0;
    inst_valid_d = 1'b0;

    unique case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
      end

      IFU_REQ: begin
        // A redirect without a handshake simply re-presents the new address.
        if (imem_req_valid && imem_req_ready) begin
          state_d = IFU_WAIT;
          drop_d  = redirect_en;
        end
      end

      IFU_WAIT: begin
        if (redirect_en) begin
          if (imem_resp_valid) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d     = IFU_OUT;
            out_d.pc    = pc;
            out_d.fault = imem_resp_err;
            out_d.inst  = imem_resp_err ? NOP_INST : select_inst(imem_rdata, pc[2]);
          end
        end
      end

      IFU_OUT: begin
        // A same-cycle redirect overrides the decoder handshake.
        if (redirect_en) begin
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          advance = 1'b1;
          state_d = IFU_REQ;
        end
        if (state_d != IFU_OUT) begin
          out_d.inst  = NOP_INST;
          out_d.fault = 1'b0;
        end
      end
    endcase

    req_valid_d  = (state_d == IFU_REQ);
    inst_valid_d = (state_d == IFU_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IFU_IDLE;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      out_q        <= IFU_OUT_RST;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      out_q        <= out_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = {pc[XLEN-1:3], 3'b000};
  assign inst_valid     = inst_valid_q;
  assign inst           = out_q.inst;
  assign inst_pc        = out_q.pc;
  assign inst_fault     = out_q.fault;

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
`timescale 1ns/1ps
module tb_ysyx_22041207_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_rdata;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  ysyx_22041207_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    int          due;
    logic [63:0] addr;
    bit          err;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          n_hs = 0;
  logic [63:0] last_hs_addr = '0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;
  bit          err_rand_en = 1'b0;
  int          err_hs_idx = -1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit dw_err(input logic [63:0] dw);
    return err_rand_en && (dw[7:3] == 5'h0B);
  endfunction

  initial begin : mem_model
    logic        hs;
    logic [63:0] ha;
    mreq_t       r;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = '0;
    imem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready;
      ha = imem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
        last_hs_addr = ha;
        mq.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)) - 1, addr: ha,
                       err: (n_hs == err_hs_idx) || dw_err(ha)});
        n_hs++;
      end
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_rdata      = {$urandom, $urandom};
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        imem_resp_valid = 1'b1;
        imem_rdata      = {mem_word(r.addr + 64'd4), mem_word(r.addr)};
        imem_resp_err   = r.err;
      end
      imem_req_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (4) step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},  64'(imem_req_valid), 64'd0);
    check({tag, "_inst_valid"}, 64'(inst_valid),     64'd0);
    check({tag, "_inst"},       64'(inst),           64'(NOP));
    check({tag, "_inst_pc"},    inst_pc,             64'd0);
    check({tag, "_fault"},      64'(inst_fault),     64'd0);
    check({tag, "_addr"},       imem_addr,           RPC);
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    bit          rdy;
    bit          red;
    logic [63:0] rpc;
    bit          e_rv;
    bit          e_iv;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
  } vec_t;

  task automatic run_table();
    vec_t        vt[20];
    logic [63:0] ei;
    // Cycle 1 is the first cycle after the IDLE cycle following reset release.
    vt[0]  = '{1'b1, 1'b0, 64'h0,          1'b1, 1'b0, 64'h0,          64'h8000_0000};
    vt[1]  = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0,          64'h8000_0000};
    vt[2]  = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_0000,  64'h8000_0000};
    vt[3]  = '{1'b1, 1'b0, 64'h0,          1'b1, 1'b0, 64'h0,          64'h8000_0000};
    vt[4]  = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0,          64'h8000_0000};
    // Redirect together with a decoder handshake: no pc+4.
    vt[5]  = '{1'b1, 1'b1, 64'h8000_2000,  1'b0, 1'b1, 64'h8000_0004,  64'h8000_0000};
    vt[6]  = '{1'b1, 1'b0, 64'h0,          1'b1, 1'b0, 64'h0,          64'h8000_2000};
    // Redirect in WAIT with the response arriving the same cycle.
    vt[7]  = '{1'b1, 1'b1, 64'h8000_1003,  1'b0, 1'b0, 64'h0,          64'h8000_2000};
    vt[8]  = '{1'b1, 1'b0, 64'h0,          1'b1, 1'b0, 64'h0,          64'h8000_1000};
    vt[9]  = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0,          64'h8000_1000};
    // Decoder stall for five cycles.
    vt[10] = '{1'b0, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1000,  64'h8000_1000};
    vt[11] = '{1'b0, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1000,  64'h8000_1000};
    vt[12] = '{1'b0, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1000,  64'h8000_1000};
    vt[13] = '{1'b0, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1000,  64'h8000_1000};
    vt[14] = '{1'b0, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1000,  64'h8000_1000};
    vt[15] = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1000,  64'h8000_1000};
    vt[16] = '{1'b1, 1'b0, 64'h0,          1'b1, 1'b0, 64'h0,          64'h8000_1000};
    vt[17] = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0,          64'h8000_1000};
    vt[18] = '{1'b1, 1'b0, 64'h0,          1'b0, 1'b1, 64'h8000_1004,  64'h8000_1000};
    vt[19] = '{1'b1, 1'b0, 64'h0,          1'b1, 1'b0, 64'h0,          64'h8000_1008};

    lat_min = 1; lat_max = 1; rdy_pct = 100; err_rand_en = 1'b0; err_hs_idx = -1;
    do_reset();
    check_reset_outputs("reset");
    for (int i = 0; i < 20; i++) begin
      step();
      inst_ready     = vt[i].rdy;
      redirect_valid = vt[i].red;
      redirect_pc    = vt[i].rpc;
      ei = vt[i].e_iv ? 64'(mem_word(vt[i].e_pc)) : 64'(NOP);
      check($sformatf("tbl%0d_req_valid", i + 1),  64'(imem_req_valid), 64'(vt[i].e_rv));
      check($sformatf("tbl%0d_inst_valid", i + 1), 64'(inst_valid),     64'(vt[i].e_iv));
      check($sformatf("tbl%0d_addr", i + 1),       imem_addr,           vt[i].e_addr);
      check($sformatf("tbl%0d_inst", i + 1),       64'(inst),           ei);
      if (vt[i].e_iv) begin
        check($sformatf("tbl%0d_inst_pc", i + 1), inst_pc,         vt[i].e_pc);
        check($sformatf("tbl%0d_fault", i + 1),   64'(inst_fault), 64'd0);
      end
    end
    redirect_valid = 1'b0;
  endtask

  // ---------------- redirect in WAIT, response arrives later ----------------
  task automatic run_redirect_wait();
    bit found;
    lat_min = 3; lat_max = 3; rdy_pct = 100;
    do_reset();
    inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req_valid) begin found = 1'b1; break; end
    end
    check("rw_req_seen", 64'(found), 64'd1);
    step();                                   // WAIT, response due in two cycles
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1003;
    check("rw_no_valid_in_wait", 64'(inst_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (inst_valid) begin found = 1'b1; break; end
      step();
    end
    check("rw_valid_seen", 64'(found), 64'd1);
    check("rw_inst_pc",    inst_pc,           64'h8000_1000);
    check("rw_inst",       64'(inst),         64'(mem_word(64'h8000_1000)));
    check("rw_req_addr",   last_hs_addr,      64'h8000_1000);
  endtask

  // ---------------- faulting fetch ----------------
  task automatic run_fault();
    logic [63:0] epc [4];
    logic [31:0] einst [4];
    bit          eflt [4];
    int          got;
    epc[0] = 64'h8000_0000; einst[0] = mem_word(64'h8000_0000); eflt[0] = 1'b0;
    epc[1] = 64'h8000_0004; einst[1] = mem_word(64'h8000_0004); eflt[1] = 1'b0;
    epc[2] = 64'h8000_0008; einst[2] = NOP;                     eflt[2] = 1'b1;
    epc[3] = 64'h8000_000C; einst[3] = mem_word(64'h8000_000C); eflt[3] = 1'b0;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    err_hs_idx = n_hs + 2;
    inst_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      step();
      if (inst_valid) begin
        check($sformatf("flt%0d_inst_pc", got), inst_pc,         epc[got]);
        check($sformatf("flt%0d_inst", got),    64'(inst),       64'(einst[got]));
        check($sformatf("flt%0d_fault", got),   64'(inst_fault), 64'(eflt[got]));
        got++;
      end
    end
    check("flt_count", 64'(got), 64'd4);
    err_hs_idx = -1;
    inst_ready = 1'b0;
  endtask

  // ---------------- reset asserted during WAIT ----------------
  task automatic run_reset_wait();
    bit found;
    int n;
    lat_min = 2; lat_max = 2; rdy_pct = 100;
    do_reset();
    inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req_valid) begin found = 1'b1; break; end
    end
    check("rst_req_seen", 64'(found), 64'd1);
    step();                                   // WAIT
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();                                   // stale response shows up now
    rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (inst_valid) begin found = 1'b1; n = i; break; end
    end
    check("rst_valid_seen", 64'(found),  64'd1);
    check("rst_latency",    64'(n),      64'd4);
    check("rst_inst_pc",    inst_pc,     RPC);
    check("rst_inst",       64'(inst),   64'(mem_word(RPC)));
    inst_ready = 1'b0;
  endtask

  // ---------------- randomized run against a transfer-level model ----------------
  task automatic run_random(input int ncyc);
    logic [63:0] mpc;
    logic [63:0] tgt;
    logic [63:0] ppc;
    logic [31:0] pinst;
    logic [31:0] ei;
    bit          ph;
    bit          red;
    bit          ef;
    int          idle;
    int          ntx;
    lat_min = 1; lat_max = 3; rdy_pct = 70; err_rand_en = 1'b1; err_hs_idx = -1;
    do_reset();
    mpc = RPC; ph = 1'b0; idle = 0; ntx = 0; ppc = '0; pinst = '0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      red = (c > 3) && ($urandom_range(11, 0) == 0);
      if ($urandom_range(3, 0) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      else                           tgt = RPC + 64'($urandom_range(1023, 0));
      inst_ready     = ($urandom_range(9, 0) < 6);
      redirect_valid = red;
      redirect_pc    = tgt;
      if (ph) begin
        check("rnd_hold_valid", 64'(inst_valid), 64'd1);
        check("rnd_hold_inst",  64'(inst),       64'(pinst));
        check("rnd_hold_pc",    inst_pc,         ppc);
      end else if (!inst_valid) begin
        check("rnd_idle_nop", 64'(inst), 64'(NOP));
      end
      if (red) begin
        mpc = {tgt[63:2], 2'b00};
      end else if (inst_valid && inst_ready) begin
        ef = dw_err({mpc[63:3], 3'b000});
        ei = ef ? NOP : mem_word(mpc);
        check("rnd_inst_pc", inst_pc,         mpc);
        check("rnd_inst",    64'(inst),       64'(ei));
        check("rnd_fault",   64'(inst_fault), 64'(ef));
        mpc  = mpc + 64'd4;
        ntx++;
        idle = 0;
      end
      ph    = inst_valid && !inst_ready && !red;
      ppc   = inst_pc;
      pinst = inst;
      idle++;
      if (idle > 200) begin
        check("rnd_progress_timeout", 64'(idle), 64'd0);
        break;
      end
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    check("rnd_enough_transfers", 64'(ntx > 100), 64'd1);
  endtask

  initial begin : main
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    run_table();
    run_redirect_wait();
    run_fault();
    run_reset_wait();
    run_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
